// File: rtl/param_sel_mux_pipe.sv
// Parametrised N-entry selector mux feeding a 2-deep skid buffer with valid/ready on both sides.
// Out-of-range selects deliver a zero word flagged as an error; completed pops are counted.
module param_sel_mux_pipe #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 32,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ENTRIES*WIDTH-1:0]   data_i,
  input  logic [SEL_W-1:0]           sel_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [WIDTH-1:0]           data_o,
  output logic                       sel_err_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CNT_W-1:0]           txn_count_o
);

  generate
    if (ENTRIES < 2 || ENTRIES > 256 || SEL_W != $clog2(ENTRIES)) begin : g_bad_params
      $error("param_sel_mux_pipe: ENTRIES must be 2..256 and SEL_W must equal clog2(ENTRIES)");
    end
  endgenerate

  logic [1:0]       count;
  logic [WIDTH-1:0] head_word;
  logic [WIDTH-1:0] tail_word;
  logic             head_err;
  logic             tail_err;
  logic [CNT_W-1:0] txn_count;

  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic             push;
  logic             pop;

  // Unmatched selects (including codes past ENTRIES) fall through to the zero/error default.
  always_comb begin
    sel_word = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < ENTRIES; k++) begin
      if (int'(sel_i) == k) begin
        sel_word = data_i[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  assign in_ready_o  = (count < 2'd2);
  assign out_valid_o = (count != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // The tail slot is kept zero whenever it is unoccupied, so shifting it into the
  // head on a pop leaves data_o/sel_err_o at zero once the buffer drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      head_word <= '0;
      head_err  <= 1'b0;
      tail_word <= '0;
      tail_err  <= 1'b0;
      txn_count <= '0;
    end else begin
      if (push && !pop) begin
        if (count == 2'd0) begin
          head_word <= sel_word;
          head_err  <= sel_bad;
        end else begin
          tail_word <= sel_word;
          tail_err  <= sel_bad;
        end
        count <= count + 2'd1;
      end else if (pop && !push) begin
        head_word <= tail_word;
        head_err  <= tail_err;
        tail_word <= '0;
        tail_err  <= 1'b0;
        count     <= count - 2'd1;
      end else if (push && pop) begin
        head_word <= sel_word;
        head_err  <= sel_bad;
      end
      if (pop) begin
        txn_count <= txn_count + 1'b1;
      end
    end
  end

  assign data_o      = head_word;
  assign sel_err_o   = head_err;
  assign txn_count_o = txn_count;

endmodule

// File: tb/tb_param_sel_mux_pipe.sv
// Directed bench: a 32-entry instance for transfer/stream/backpressure/reset checks and
// a 20-entry, 4-bit-counter instance for out-of-range selects and counter wrap.
module tb_param_sel_mux_pipe;

  logic          clk;
  logic          reset;

  logic [1023:0] data_a;
  logic [4:0]    sel_a;
  logic          in_valid_a;
  logic          in_ready_a;
  logic [31:0]   dout_a;
  logic          err_a;
  logic          out_valid_a;
  logic          out_ready_a;
  logic [15:0]   cnt_a;

  logic [639:0]  data_b;
  logic [4:0]    sel_b;
  logic          in_valid_b;
  logic          in_ready_b;
  logic [31:0]   dout_b;
  logic          err_b;
  logic          out_valid_b;
  logic          out_ready_b;
  logic [3:0]    cnt_b;

  int checks;
  int failures;

  param_sel_mux_pipe #(.WIDTH(32), .ENTRIES(32), .SEL_W(5), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .data_i(data_a), .sel_i(sel_a),
    .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .data_o(dout_a),
    .sel_err_o(err_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
    .txn_count_o(cnt_a)
  );

  param_sel_mux_pipe #(.WIDTH(32), .ENTRIES(20), .SEL_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .data_i(data_b), .sel_i(sel_b),
    .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .data_o(dout_b),
    .sel_err_o(err_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
    .txn_count_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the 32-entry instance's handshake inputs, then advance one edge.
  task automatic applyStimulus(input logic valid, input logic [4:0] sel, input logic ready);
    in_valid_a  = valid;
    sel_a       = sel;
    out_ready_a = ready;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 32; k++) data_a[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    for (int k = 0; k < 20; k++) data_b[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    sel_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    sel_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0;

    // Reset state
    reset = 1'b1;
    #2;
    tick();
    checkOutput("rst_valid", 32'(out_valid_a), 32'd0);
    checkOutput("rst_ready", 32'(in_ready_a), 32'd1);
    checkOutput("rst_data", dout_a, 32'd0);
    checkOutput("rst_err", 32'(err_a), 32'd0);
    checkOutput("rst_cnt", 32'(cnt_a), 32'd0);
    reset = 1'b0;

    // Single transfer, sel 7
    applyStimulus(1'b1, 5'd7, 1'b1);
    checkOutput("t1_valid", 32'(out_valid_a), 32'd1);
    checkOutput("t1_data", dout_a, 32'hA000_0007);
    checkOutput("t1_ready", 32'(in_ready_a), 32'd1);
    applyStimulus(1'b0, 5'd0, 1'b1);
    checkOutput("t1_pop_valid", 32'(out_valid_a), 32'd0);
    checkOutput("t1_pop_data", dout_a, 32'd0);
    checkOutput("t1_cnt", 32'(cnt_a), 32'd1);

    // Back-to-back streaming of all 32 entries
    for (int i = 0; i < 32; i++) begin
      checkOutput("t2_in_ready", 32'(in_ready_a), 32'd1);
      applyStimulus(1'b1, 5'(i), 1'b1);
      checkOutput("t2_valid", 32'(out_valid_a), 32'd1);
      checkOutput("t2_data", dout_a, 32'hA000_0000 + 32'(i));
    end
    applyStimulus(1'b0, 5'd0, 1'b1);
    checkOutput("t2_drained", 32'(out_valid_a), 32'd0);
    checkOutput("t2_cnt", 32'(cnt_a), 32'd33);

    // Backpressure: 3 and 4 fill the buffer, 5 is held off
    applyStimulus(1'b1, 5'd3, 1'b0);
    checkOutput("t3_data_a", dout_a, 32'hA000_0003);
    checkOutput("t3_ready_a", 32'(in_ready_a), 32'd1);
    applyStimulus(1'b1, 5'd4, 1'b0);
    checkOutput("t3_ready_full", 32'(in_ready_a), 32'd0);
    checkOutput("t3_data_hold", dout_a, 32'hA000_0003);
    applyStimulus(1'b1, 5'd5, 1'b0);
    checkOutput("t3_ready_stall", 32'(in_ready_a), 32'd0);
    checkOutput("t3_data_stall", dout_a, 32'hA000_0003);
    checkOutput("t3_valid_stall", 32'(out_valid_a), 32'd1);
    applyStimulus(1'b1, 5'd5, 1'b1);
    checkOutput("t3_out4", dout_a, 32'hA000_0004);
    checkOutput("t3_ready_reopen", 32'(in_ready_a), 32'd1);
    applyStimulus(1'b1, 5'd5, 1'b1);
    checkOutput("t3_out5", dout_a, 32'hA000_0005);
    applyStimulus(1'b0, 5'd0, 1'b1);
    checkOutput("t3_drained", 32'(out_valid_a), 32'd0);
    checkOutput("t3_cnt", 32'(cnt_a), 32'd36);

    // Out-of-range select on the 20-entry instance, then sel 19
    in_valid_b = 1'b1; sel_b = 5'd25; out_ready_b = 1'b1;
    tick();
    checkOutput("t4_err_data", dout_b, 32'd0);
    checkOutput("t4_err_flag", 32'(err_b), 32'd1);
    checkOutput("t4_err_valid", 32'(out_valid_b), 32'd1);
    sel_b = 5'd19;
    tick();
    checkOutput("t4_data19", dout_b, 32'hA000_0013);
    checkOutput("t4_err19", 32'(err_b), 32'd0);
    checkOutput("t4_cnt", 32'(cnt_b), 32'd1);

    // Counter wrap: 15 further transfers take the 4-bit count through 15, 0, 1
    for (int i = 0; i < 15; i++) begin
      sel_b = 5'(i);
      tick();
      checkOutput("t6_data", dout_b, 32'hA000_0000 + 32'(i));
      checkOutput("t6_cnt", 32'(cnt_b), 32'((2 + i) % 16));
    end
    in_valid_b = 1'b0;
    tick();
    checkOutput("t6_cnt_final", 32'(cnt_b), 32'd1);
    checkOutput("t6_drained", 32'(out_valid_b), 32'd0);

    // Reset with a full buffer: nothing buffered may ever appear
    applyStimulus(1'b1, 5'd10, 1'b0);
    applyStimulus(1'b1, 5'd11, 1'b0);
    checkOutput("t5_full", 32'(in_ready_a), 32'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 5'd12, 1'b1);
    reset = 1'b0;
    checkOutput("t5_valid", 32'(out_valid_a), 32'd0);
    checkOutput("t5_ready", 32'(in_ready_a), 32'd1);
    checkOutput("t5_data", dout_a, 32'd0);
    checkOutput("t5_cnt", 32'(cnt_a), 32'd0);
    checkOutput("t5_cnt_b", 32'(cnt_b), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b1);
      checkOutput("t5_no_ghost", 32'(out_valid_a), 32'd0);
      checkOutput("t5_cnt_hold", 32'(cnt_a), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
